// File: rtl/axi_proxy_rx.sv
// AXI-Stream to AXI4-Lite write proxy: each accepted 512-bit packet becomes one
// single-beat AXI4-Lite write, with optional marker validation and response counters.
module axi_proxy_rx #(
  parameter bit          CHECK_MARKERS = 1'b1,
  parameter logic [31:0] MARKER0       = 32'hBEADCAFE,
  parameter logic [31:0] MARKER1       = 32'hFADEDBAD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] S_AXIS_TDATA,
  input  logic         S_AXIS_TVALID,
  output logic         S_AXIS_TREADY,
  output logic [31:0]  M_AXI_AWADDR,
  output logic         M_AXI_AWVALID,
  input  logic         M_AXI_AWREADY,
  output logic [2:0]   M_AXI_AWPROT,
  output logic [31:0]  M_AXI_WDATA,
  output logic [3:0]   M_AXI_WSTRB,
  output logic         M_AXI_WVALID,
  input  logic         M_AXI_WREADY,
  input  logic [1:0]   M_AXI_BRESP,
  input  logic         M_AXI_BVALID,
  output logic         M_AXI_BREADY,
  output logic         busy,
  output logic [31:0]  ok_count,
  output logic [31:0]  err_count,
  output logic [31:0]  bad_marker_count,
  output logic [1:0]   last_bresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        tready_q, tready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] ok_count_q, ok_count_d;
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] bad_count_q, bad_count_d;
  logic [1:0]  last_bresp_q, last_bresp_d;

  logic        marker_ok;
  logic        aw_done;
  logic        w_done;
  logic        unused_tdata;

  assign unused_tdata = ^S_AXIS_TDATA[447:64];

  assign marker_ok = !CHECK_MARKERS ||
                     ((S_AXIS_TDATA[511:480] == MARKER0) &&
                      (S_AXIS_TDATA[479:448] == MARKER1));

  // A channel counts as done once its VALID is low or is being accepted this cycle.
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    ok_count_d   = ok_count_q;
    err_count_d  = err_count_q;
    bad_count_d  = bad_count_q;
    last_bresp_d = last_bresp_q;

    unique case (state_q)
      IDLE: begin
        if (S_AXIS_TVALID && tready_q) begin
          if (marker_ok) begin
            awaddr_d  = S_AXIS_TDATA[63:32];
            wdata_d   = S_AXIS_TDATA[31:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            bad_count_d = bad_count_q + 32'd1;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done)          state_d   = WAIT_B;
      end
      WAIT_B: begin
        if (M_AXI_BVALID) begin
          last_bresp_d = M_AXI_BRESP;
          if (M_AXI_BRESP == 2'b00) ok_count_d  = ok_count_q + 32'd1;
          else                      err_count_d = err_count_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so TREADY has no path from TVALID and
    // stays low until the first edge after reset.
    tready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      ok_count_q   <= '0;
      err_count_q  <= '0;
      bad_count_q  <= '0;
      last_bresp_q <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      ok_count_q   <= ok_count_d;
      err_count_q  <= err_count_d;
      bad_count_q  <= bad_count_d;
      last_bresp_q <= last_bresp_d;
    end
  end

  assign S_AXIS_TREADY    = tready_q;
  assign M_AXI_AWADDR     = awaddr_q;
  assign M_AXI_AWVALID    = awvalid_q;
  assign M_AXI_AWPROT     = 3'b000;
  assign M_AXI_WDATA      = wdata_q;
  assign M_AXI_WSTRB      = 4'hF;
  assign M_AXI_WVALID     = wvalid_q;
  assign M_AXI_BREADY     = (state_q == WAIT_B);
  assign busy             = (state_q != IDLE);
  assign ok_count         = ok_count_q;
  assign err_count        = err_count_q;
  assign bad_marker_count = bad_count_q;
  assign last_bresp       = last_bresp_q;

endmodule
